// File: rtl/register_file_scoreboard.sv
// Register file with a pending-register scoreboard.
// 32 x DATA_WIDTH registers: r0 hard-wired to zero, r29 resets to the stack pointer.
// Two combinational read ports with same-cycle write bypass.
// A busy bit per register marks the register as awaiting a multi-cycle producer.
// stall_o requests that issue be held while a needed operand is still busy.
module register_file_scoreboard #(
  parameter int unsigned             DATA_WIDTH = 32,
  parameter int unsigned             ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0]   SP_RESET   = 32'h7FFF_EFFC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write_i,
  input  logic [ADDR_WIDTH-1:0] write_register_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic [ADDR_WIDTH-1:0] read_register_1_i,
  input  logic [ADDR_WIDTH-1:0] read_register_2_i,
  output logic [DATA_WIDTH-1:0] read_data_1_o,
  output logic [DATA_WIDTH-1:0] read_data_2_o,
  input  logic                  reserve_i,
  input  logic [ADDR_WIDTH-1:0] reserve_register_i,
  input  logic                  use_rs_i,
  input  logic                  use_rt_i,
  output logic                  stall_o,
  output logic [ADDR_WIDTH:0]   busy_count_o
);

  localparam int unsigned NREG = 1 << ADDR_WIDTH;
  localparam int unsigned SP_IDX = 29;

  logic [DATA_WIDTH-1:0] r_regs [NREG];
  logic [NREG-1:0]       r_busy;
  logic [ADDR_WIDTH:0]   r_count;

  logic                  w_we;
  logic                  w_res;
  logic                  w_hit1;
  logic                  w_hit2;
  logic [NREG-1:0]       w_busy_next;
  logic                  w_inc;
  logic                  w_dec;

  // Accepted write/reserve: nonzero index and not held in reset.
  always_comb begin
    w_we   = reg_write_i && (write_register_i != '0) && !reset;
    w_res  = reserve_i && (reserve_register_i != '0) && !reset;
    w_hit1 = w_we && (write_register_i == read_register_1_i);
    w_hit2 = w_we && (write_register_i == read_register_2_i);
  end

  // Read ports with bypass of the write being accepted this cycle.
  always_comb begin
    read_data_1_o = w_hit1 ? write_data_i : r_regs[read_register_1_i];
    read_data_2_o = w_hit2 ? write_data_i : r_regs[read_register_2_i];
  end

  // Operand hazard: a busy source is only safe if its producer writes back now.
  always_comb begin
    stall_o = (use_rs_i && r_busy[read_register_1_i] && !w_hit1) ||
              (use_rt_i && r_busy[read_register_2_i] && !w_hit2);
  end

  // Busy vector update and the matching count delta; a reserve to the register
  // being written in the same cycle wins, so that write must not decrement.
  always_comb begin
    w_busy_next = r_busy;
    if (w_we)
      w_busy_next[write_register_i] = 1'b0;
    if (w_res)
      w_busy_next[reserve_register_i] = 1'b1;
    w_busy_next[0] = 1'b0;
    w_inc = w_res && !r_busy[reserve_register_i];
    w_dec = w_we && r_busy[write_register_i] &&
            !(w_res && (reserve_register_i == write_register_i));
  end

  // Register storage: r29 comes out of reset holding the initial stack pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++)
        r_regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
    end else if (w_we) begin
      r_regs[write_register_i] <= write_data_i;
    end
  end

  // Scoreboard state: busy bits plus an incrementally maintained popcount.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= w_busy_next;
      r_count <= r_count + {{ADDR_WIDTH{1'b0}}, w_inc} - {{ADDR_WIDTH{1'b0}}, w_dec};
    end
  end

  assign busy_count_o = r_count;

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed bench for register_file_scoreboard.
// Stimulus drives one cycle at a time (#1 after the rising edge) and pushes the
// expected outputs for that cycle; a monitor pops and compares on the falling edge.
module tb_register_file_scoreboard;

  localparam logic [31:0] SP = 32'h7FFF_EFFC;

  logic        clk;
  logic        reset;
  logic        reg_write_i;
  logic [4:0]  write_register_i;
  logic [31:0] write_data_i;
  logic [4:0]  read_register_1_i;
  logic [4:0]  read_register_2_i;
  logic [31:0] read_data_1_o;
  logic [31:0] read_data_2_o;
  logic        reserve_i;
  logic [4:0]  reserve_register_i;
  logic        use_rs_i;
  logic        use_rt_i;
  logic        stall_o;
  logic [5:0]  busy_count_o;

  register_file_scoreboard #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .SP_RESET(SP)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .reg_write_i        (reg_write_i),
    .write_register_i   (write_register_i),
    .write_data_i       (write_data_i),
    .read_register_1_i  (read_register_1_i),
    .read_register_2_i  (read_register_2_i),
    .read_data_1_o      (read_data_1_o),
    .read_data_2_o      (read_data_2_o),
    .reserve_i          (reserve_i),
    .reserve_register_i (reserve_register_i),
    .use_rs_i           (use_rs_i),
    .use_rt_i           (use_rt_i),
    .stall_o            (stall_o),
    .busy_count_o       (busy_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mask bits: 0 rd1, 1 rd2, 2 stall, 3 count
  typedef struct {
    string       name;
    logic [3:0]  mask;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        stall;
    logic [5:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Monitor: compare every pending expectation against the settled outputs.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.mask[0]) begin
        n_vec++;
        if (read_data_1_o !== e.rd1) begin
          n_err++;
          $display("FAIL %s rd1: got %h expected %h", e.name, read_data_1_o, e.rd1);
        end
      end
      if (e.mask[1]) begin
        n_vec++;
        if (read_data_2_o !== e.rd2) begin
          n_err++;
          $display("FAIL %s rd2: got %h expected %h", e.name, read_data_2_o, e.rd2);
        end
      end
      if (e.mask[2]) begin
        n_vec++;
        if (stall_o !== e.stall) begin
          n_err++;
          $display("FAIL %s stall: got %b expected %b", e.name, stall_o, e.stall);
        end
      end
      if (e.mask[3]) begin
        n_vec++;
        if (busy_count_o !== e.cnt) begin
          n_err++;
          $display("FAIL %s count: got %0d expected %0d", e.name, busy_count_o, e.cnt);
        end
      end
    end
  end

  task automatic cyc(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt,
                     input logic res, input logic [4:0] resr);
    @(posedge clk);
    #1;
    reg_write_i        = we;
    write_register_i   = wr;
    write_data_i       = wd;
    read_register_1_i  = rs;
    read_register_2_i  = rt;
    use_rs_i           = urs;
    use_rt_i           = urt;
    reserve_i          = res;
    reserve_register_i = resr;
  endtask

  task automatic expect_out(input string nm, input logic [3:0] m, input logic [31:0] e1,
                            input logic [31:0] e2, input logic es, input logic [5:0] ec);
    exp_t e;
    e.name = nm; e.mask = m; e.rd1 = e1; e.rd2 = e2; e.stall = es; e.cnt = ec;
    q.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    reg_write_i = 1'b0; write_register_i = '0; write_data_i = '0;
    read_register_1_i = '0; read_register_2_i = '0;
    use_rs_i = 1'b0; use_rt_i = 1'b0; reserve_i = 1'b0; reserve_register_i = '0;

    // Reset values; write/reserve attempts during reset are ignored, no bypass.
    cyc(1, 5'd29, 32'h1234, 5'd29, 5'd0, 1, 1, 1, 5'd29);
    expect_out("reset_state", 4'b1111, SP, 32'h0, 1'b0, 6'd0);
    cyc(0, 5'd0, 32'h0, 5'd29, 5'd0, 0, 0, 0, 5'd0);
    reset = 1'b0;
    expect_out("reset_write_ignored", 4'b1111, SP, 32'h0, 1'b0, 6'd0);

    // Write and bypass; r0 stays zero.
    cyc(1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd29, 0, 0, 0, 5'd0);
    expect_out("bypass_r8", 4'b0011, 32'hDEAD_BEEF, SP, 1'b0, 6'd0);
    cyc(1, 5'd0, 32'h5, 5'd8, 5'd0, 0, 0, 0, 5'd0);
    expect_out("r8_stored_r0_nobypass", 4'b0011, 32'hDEAD_BEEF, 32'h0, 1'b0, 6'd0);
    cyc(0, 5'd0, 32'h0, 5'd0, 5'd8, 0, 0, 0, 5'd0);
    expect_out("r0_reads_zero", 4'b0011, 32'h0, 32'hDEAD_BEEF, 1'b0, 6'd0);

    // Reserve r9, stall on use, writeback clears.
    cyc(0, 5'd0, 32'h0, 5'd9, 5'd0, 1, 0, 1, 5'd9);
    expect_out("reserve_r9_before_edge", 4'b1100, 32'h0, 32'h0, 1'b0, 6'd0);
    cyc(0, 5'd0, 32'h0, 5'd9, 5'd0, 1, 0, 0, 5'd0);
    expect_out("r9_busy_stall", 4'b1100, 32'h0, 32'h0, 1'b1, 6'd1);
    cyc(1, 5'd9, 32'h7, 5'd9, 5'd0, 1, 0, 0, 5'd0);
    expect_out("r9_writeback_hit", 4'b1101, 32'h7, 32'h0, 1'b0, 6'd1);
    cyc(0, 5'd0, 32'h0, 5'd9, 5'd0, 1, 0, 0, 5'd0);
    expect_out("r9_cleared", 4'b1101, 32'h7, 32'h0, 1'b0, 6'd0);

    // Same-edge reserve and write of r10: reserve wins.
    cyc(1, 5'd10, 32'h3, 5'd0, 5'd0, 0, 0, 1, 5'd10);
    expect_out("r10_res_write", 4'b1000, 32'h0, 32'h0, 1'b0, 6'd0);
    cyc(0, 5'd0, 32'h0, 5'd10, 5'd0, 1, 0, 0, 5'd0);
    expect_out("r10_still_busy", 4'b1101, 32'h3, 32'h0, 1'b1, 6'd1);
    cyc(0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 0, 1, 5'd12);
    expect_out("reserve_r12", 4'b1000, 32'h0, 32'h0, 1'b0, 6'd1);
    cyc(1, 5'd12, 32'h55, 5'd0, 5'd0, 0, 0, 1, 5'd11);
    expect_out("res11_wr12", 4'b1000, 32'h0, 32'h0, 1'b0, 6'd2);
    cyc(0, 5'd0, 32'h0, 5'd12, 5'd11, 1, 0, 0, 5'd0);
    expect_out("count_net_zero", 4'b1101, 32'h55, 32'h0, 1'b0, 6'd2);
    cyc(0, 5'd0, 32'h0, 5'd12, 5'd11, 1, 1, 0, 5'd0);
    expect_out("rt11_busy_stall", 4'b0100, 32'h0, 32'h0, 1'b1, 6'd2);

    // Fill the scoreboard.
    for (int i = 1; i < 32; i++)
      cyc(0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 0, 1, i[4:0]);
    cyc(0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 0, 1, 5'd5);
    expect_out("all_reserved", 4'b1000, 32'h0, 32'h0, 1'b0, 6'd31);
    cyc(0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 0, 1, 5'd0);
    expect_out("rereserve_r5", 4'b1000, 32'h0, 32'h0, 1'b0, 6'd31);
    cyc(0, 5'd0, 32'h0, 5'd7, 5'd0, 0, 1, 0, 5'd0);
    expect_out("reserve_r0_no_change_unused_rs", 4'b1100, 32'h0, 32'h0, 1'b0, 6'd31);
    cyc(0, 5'd0, 32'h0, 5'd7, 5'd0, 1, 0, 0, 5'd0);
    expect_out("rs7_busy_stall", 4'b0100, 32'h0, 32'h0, 1'b1, 6'd31);
    cyc(1, 5'd20, 32'h20, 5'd0, 5'd0, 0, 0, 0, 5'd0);
    expect_out("write_r20_full", 4'b1000, 32'h0, 32'h0, 1'b0, 6'd31);
    cyc(0, 5'd0, 32'h0, 5'd20, 5'd0, 1, 0, 0, 5'd0);
    expect_out("r20_released", 4'b1101, 32'h20, 32'h0, 1'b0, 6'd30);

    // Reset from a full scoreboard.
    cyc(0, 5'd0, 32'h0, 5'd20, 5'd0, 1, 0, 0, 5'd0);
    reset = 1'b1;
    expect_out("reset_full", 4'b1101, 32'h0, 32'h0, 1'b0, 6'd0);
    cyc(1, 5'd3, 32'hAB, 5'd3, 5'd0, 0, 0, 0, 5'd0);
    reset = 1'b0;
    expect_out("write_r3", 4'b1001, 32'hAB, 32'h0, 1'b0, 6'd0);
    cyc(0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 0, 1, 5'd3);
    expect_out("reserve_r3", 4'b1000, 32'h0, 32'h0, 1'b0, 6'd0);
    cyc(0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 0, 1, 5'd4);
    expect_out("reserve_r4", 4'b1000, 32'h0, 32'h0, 1'b0, 6'd1);
    cyc(0, 5'd0, 32'h0, 5'd3, 5'd4, 1, 1, 0, 5'd0);
    expect_out("r3_r4_pending", 4'b1101, 32'hAB, 32'h0, 1'b1, 6'd2);
    cyc(0, 5'd0, 32'h0, 5'd3, 5'd4, 1, 1, 0, 5'd0);
    reset = 1'b1;
    expect_out("midcycle_reset", 4'b1111, 32'h0, 32'h0, 1'b0, 6'd0);
    cyc(0, 5'd0, 32'h0, 5'd29, 5'd3, 1, 1, 1, 5'd5);
    reset = 1'b0;
    expect_out("after_release", 4'b1111, SP, 32'h0, 1'b0, 6'd0);
    cyc(0, 5'd0, 32'h0, 5'd5, 5'd3, 1, 1, 0, 5'd0);
    expect_out("first_edge_reserve", 4'b1100, 32'h0, 32'h0, 1'b1, 6'd1);

    // Bounded drain of outstanding expectations.
    for (int k = 0; k < 10 && q.size() > 0; k++)
      @(posedge clk);
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
